// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of word stores draining to data memory, with youngest-match load forwarding.
// Latency: a push becomes visible at the next edge and drains one entry per cycle while dm_busy is low.
// Backpressure: st_ready drops when the buffer is full, and the head is held while dm_busy is high.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [31:0]                st_pc,
    output logic                       st_ready,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hit,
    output logic [31:0]                ld_data,
    input  logic                       dm_busy,
    output logic                       dm_we,
    output logic [31:0]                dm_addr,
    output logic [31:0]                dm_wdata,
    output logic [31:0]                dm_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;

    // Only the word-index bits of a load address take part in the lookup.
    logic unused_ld_bits;
    assign unused_ld_bits = &{1'b0, ld_addr[31:12], ld_addr[1:0]};

    assign st_ready = (cnt < FULL);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign push     = st_valid & st_ready;
    assign dm_we    = ~empty & ~dm_busy;
    assign pop      = dm_we;

    assign dm_addr  = empty ? 32'd0 : addr_q[head];
    assign dm_wdata = empty ? 32'd0 : data_q[head];
    assign dm_pc    = empty ? 32'd0 : pc_q[head];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage is left uninitialised; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
            pc_q[tail]   <= st_pc;
        end
    end

    // Walk from oldest to youngest so the last match seen (closest to tail) wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = 32'd0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < cnt) && (addr_q[idx][11:2] == ld_addr[11:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4).
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        Reset;
    logic        st_valid;
    logic [31:0] st_addr, st_data, st_pc;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        dm_busy;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wdata, dm_pc;
    logic [2:0]  count;
    logic        empty;

    int n_chk  = 0;
    int n_fail = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .Reset    (Reset),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_pc    (st_pc),
        .st_ready (st_ready),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .dm_busy  (dm_busy),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_pc    (dm_pc),
        .count    (count),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_pc    = p;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ready"}, 32'(st_ready), 32'd1);
        check({tag, "_we"}, 32'(dm_we), 32'd0);
        check({tag, "_hit"}, 32'(ld_hit), 32'd0);
        check({tag, "_ldata"}, ld_data, 32'd0);
        check({tag, "_daddr"}, dm_addr, 32'd0);
        check({tag, "_wdata"}, dm_wdata, 32'd0);
        check({tag, "_pc"}, dm_pc, 32'd0);
    endtask

    initial begin
        Reset    = 1'b0;
        st_valid = 1'b0;
        st_addr  = 32'd0;
        st_data  = 32'd0;
        st_pc    = 32'd0;
        ld_addr  = 32'd0;
        dm_busy  = 1'b0;
        #3;
        check_idle("rst");
        @(posedge clk);
        #2 Reset = 1'b1;
        tick();
        check_idle("post_rst");

        // Single store held by dm_busy, then drained
        dm_busy = 1'b1;
        push(32'h10, 32'hAAAA0001, 32'h100);
        check("s1_count", 32'(count), 32'd1);
        check("s1_we_busy", 32'(dm_we), 32'd0);
        dm_busy = 1'b0;
        #1;
        check("s1_we", 32'(dm_we), 32'd1);
        check("s1_addr", dm_addr, 32'h10);
        check("s1_wdata", dm_wdata, 32'hAAAA0001);
        check("s1_pc", dm_pc, 32'h100);
        tick();
        check("s1_empty", 32'(empty), 32'd1);
        check("s1_we_after", 32'(dm_we), 32'd0);

        // Fill to DEPTH, ignore overflow store, drain in order
        dm_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h40 + 32'(4*i), 32'hB000_0000 + 32'(i), 32'h200 + 32'(4*i));
        check("full_ready", 32'(st_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        push(32'h80, 32'hDEAD_BEEF, 32'h300);
        check("ovf_count", 32'(count), 32'd4);
        ld_addr = 32'h80;
        #1;
        check("ovf_hit", 32'(ld_hit), 32'd0);
        dm_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_drain_we", 32'(dm_we), 32'd1);
            check("full_drain_data", dm_wdata, 32'hB000_0000 + 32'(i));
            check("full_drain_addr", dm_addr, 32'h40 + 32'(4*i));
            tick();
        end
        check("full_drained", 32'(empty), 32'd1);
        check("full_no_extra", 32'(dm_we), 32'd0);

        // Youngest match wins; compare on [11:2] only
        dm_busy = 1'b1;
        push(32'h20, 32'd1, 32'h400);
        push(32'h20, 32'd2, 32'h404);
        ld_addr = 32'h20;
        #1;
        check("fwd_hit", 32'(ld_hit), 32'd1);
        check("fwd_data", ld_data, 32'd2);
        ld_addr = 32'h1023;
        #1;
        check("fwd_alias_hit", 32'(ld_hit), 32'd1);
        check("fwd_alias_data", ld_data, 32'd2);
        ld_addr = 32'h24;
        #1;
        check("fwd_miss_hit", 32'(ld_hit), 32'd0);
        check("fwd_miss_data", ld_data, 32'd0);
        dm_busy = 1'b0;
        #1;
        check("same_word_first", dm_wdata, 32'd1);
        tick();
        check("same_word_second", dm_wdata, 32'd2);
        tick();
        check("fwd_drained", 32'(empty), 32'd1);

        // Pushing store not visible same cycle; drained entry visible until its edge
        dm_busy  = 1'b1;
        ld_addr  = 32'h30;
        st_valid = 1'b1;
        st_addr  = 32'h30;
        st_data  = 32'h3333;
        st_pc    = 32'h500;
        #1;
        check("push_invisible", 32'(ld_hit), 32'd0);
        tick();
        st_valid = 1'b0;
        check("push_visible", 32'(ld_hit), 32'd1);
        check("push_visible_data", ld_data, 32'h3333);
        dm_busy = 1'b0;
        #1;
        check("pop_cycle_we", 32'(dm_we), 32'd1);
        check("pop_cycle_hit", 32'(ld_hit), 32'd1);
        tick();
        check("after_pop_hit", 32'(ld_hit), 32'd0);
        check("after_pop_data", ld_data, 32'd0);

        // Steady push+pop at count=2, pointers wrap, order preserved
        dm_busy = 1'b1;
        push(32'h100, 32'hC0, 32'h600);
        push(32'h104, 32'hC1, 32'h604);
        dm_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'h108 + 32'(4*k);
            st_data  = 32'hC2 + 32'(k);
            st_pc    = 32'h608 + 32'(4*k);
            #1;
            check("stream_count", 32'(count), 32'd2);
            check("stream_ready", 32'(st_ready), 32'd1);
            check("stream_data", dm_wdata, 32'hC0 + 32'(k));
            tick();
        end
        st_valid = 1'b0;
        check("stream_tail_count", 32'(count), 32'd2);
        check("stream_tail0", dm_wdata, 32'hC6);
        tick();
        check("stream_tail1", dm_wdata, 32'hC7);
        check("stream_tail1_pc", dm_pc, 32'h61C);
        tick();
        check("stream_empty", 32'(empty), 32'd1);

        // Mid-cycle reset discards buffered stores
        dm_busy = 1'b1;
        push(32'h50, 32'h51, 32'h700);
        push(32'h54, 32'h55, 32'h704);
        push(32'h58, 32'h59, 32'h708);
        check("prerst_count", 32'(count), 32'd3);
        ld_addr = 32'h54;
        #2;
        dm_busy = 1'b0;
        Reset   = 1'b0;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #2 Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_stale_we", 32'(dm_we), 32'd0);
        end
        check("no_stale_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffered store entries; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL have port clk  input  1  meaning system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset  input  1  meaning asynchronous, active-low reset.
REQ-004 The block SHALL have port st_valid  input  1  meaning the CPU MEM stage presents a word store this cycle.
REQ-005 The block SHALL have port st_addr  input  32  meaning store byte address; only bits [11:2] are significant.
REQ-006 The block SHALL have port st_data  input  32  meaning store data word.
REQ-007 The block SHALL have port st_pc  input  32  meaning PC of the store instruction, carried for trace.
REQ-008 The block SHALL have port st_ready  output  1  meaning the buffer accepts a store this cycle.
REQ-009 The block SHALL have port ld_addr  input  32  meaning load byte address for forwarding lookup.
REQ-010 The block SHALL have port ld_hit  output  1  meaning a buffered store matches ld_addr[11:2].
REQ-011 The block SHALL have port ld_data  output  32  meaning data of the youngest matching entry, 0 when ld_hit=0.
REQ-012 The block SHALL have port dm_busy  input  1  meaning data memory cannot take a write this cycle.
REQ-013 The block SHALL have port dm_we  output  1  meaning write strobe to data memory (DWE).
REQ-014 The block SHALL have ports dm_addr, dm_wdata and dm_pc  output  32 each  meaning address, data and PC of the head entry.
REQ-015 The block SHALL have port count  output  log2(DEPTH)+1  meaning number of valid entries.
REQ-016 The block SHALL have port empty  output  1  meaning count==0.

Function
REQ-017 The buffer SHALL be a circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 st_ready SHALL be 1 exactly when count<DEPTH; it SHALL NOT depend on a same-cycle drain.
REQ-019 A push SHALL occur on a rising edge with st_valid=1 and st_ready=1: write the entry at tail, then advance tail.
REQ-020 Stores presented while st_ready=0 SHALL be ignored; holding st_valid until accepted is the upstream stall's responsibility.
REQ-021 dm_we SHALL equal (count!=0) and (dm_busy=0), combinationally.
REQ-022 dm_addr, dm_wdata and dm_pc SHALL show the head entry whenever count!=0, and 0 when empty.
REQ-023 A pop SHALL occur on a rising edge where dm_we=1: advance head; one entry drained per cycle maximum.
REQ-024 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 count SHALL change by +1 on push only, by -1 on pop only, and never exceed DEPTH or go below 0.
REQ-026 ld_hit/ld_data SHALL be combinational over all valid entries, compared on [11:2], with the youngest match (closest to tail) winning.
REQ-027 An entry popped on this edge SHALL still be visible to forwarding during the cycle before that edge.
REQ-028 A store being pushed in the current cycle SHALL NOT be visible to forwarding until the following cycle.
REQ-029 Stores to the same word SHALL drain in program order; no coalescing.
REQ-030 Write latency SHALL be: a store pushed at edge N reaches DM no earlier than edge N+1 and only after all older entries have drained.

Reset
REQ-031 While Reset=0, head, tail and count SHALL be forced to 0 immediately, independent of clk.
REQ-032 During and after reset: empty=1, st_ready=1, dm_we=0, ld_hit=0, ld_data=0, dm_addr=dm_wdata=dm_pc=0.
REQ-033 Entry storage need not be cleared; it SHALL be unobservable while its slot is invalid.
REQ-034 Reset asserted mid-operation SHALL discard all buffered stores; no dm_we pulse SHALL be generated for them.

Verification
REQ-035 Push 0x10->0xAAAA0001 with dm_busy=1 -> count=1, dm_we=0; release dm_busy -> dm_we=1, dm_addr=0x10, dm_wdata=0xAAAA0001 for one cycle, then empty=1.
REQ-036 With dm_busy=1, push DEPTH=4 stores -> st_ready=0, count=4; a 5th st_valid pulse is ignored; after release, exactly 4 writes are issued in order.
REQ-037 Push 0x20->1 then 0x20->2, and set ld_addr=0x20 -> ld_hit=1, ld_data=2; ld_addr=0x24 -> ld_hit=0, ld_data=0.
REQ-038 count=2 with dm_busy=0 and st_valid=1 each cycle -> count stays 2; after 6 pushes the pointers wrap and DM writes appear in push order.
REQ-039 Assert Reset=0 between clock edges with count=3 -> outputs reach reset values before the next edge; after release, no stale writes.
REQ-040 Drain edge and ld_addr at head address -> ld_hit=1 in the cycle before the edge and ld_hit=0 after it (no other match).
